fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have exactly one clock and one asynchronous, active-low reset.
REQ-002 The port list SHALL be as follows (clock and reset first):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- PCSrc  input  1  branch-taken redirect from the branch stage
- exNPC  input  10  redirect target PC
- imem_req  output  1  single-cycle instruction-memory read request
- imem_addr  output  10  word address of the request
- imem_valid  input  1  read data valid, one or more cycles after imem_req
- imem_rdata  input  32  instruction word
- instr  output  32  fetched instruction: opcode[31:29], fcode[28:25], label[24:0]
- instr_PC  output  10  PC of instr
- instr_valid  output  1  instr/instr_PC valid to decode
- instr_ready  input  1  decode accepts instr
- halted  output  1  fetch stopped on HALT

Function
REQ-003 FSM states SHALL be IDLE, FETCH, WAIT, OUT and HALT.
REQ-004 IDLE SHALL be left unconditionally for FETCH one cycle after reset release.
REQ-005 In FETCH with PCSrc=0:
- imem_req=1 and imem_addr=PC, combinationally;
- next state WAIT.
REQ-006 In FETCH with PCSrc=1:
- imem_req=0;
- PC<=exNPC;
- state stays FETCH.
REQ-007 At most one memory request SHALL be outstanding at any time.
REQ-008 In WAIT with imem_valid=1, squash=0 and PCSrc=0:
- instr<=imem_rdata and instr_PC<=PC;
- PC<=PC+1, modulo 1024 (1023 wraps to 0);
- next state OUT.
REQ-009 In WAIT with PCSrc=1 and imem_valid=0:
- PC<=exNPC;
- squash<=1;
- state stays WAIT.
REQ-010 In WAIT with imem_valid=1 and (squash=1 or PCSrc=1):
- data SHALL be discarded;
- squash<=0;
- PC<=exNPC if PCSrc=1, otherwise PC is unchanged;
- next state FETCH.
REQ-011 In OUT, instr_valid=1; instr and instr_PC SHALL hold stable until instr_ready=1 or PCSrc=1.
REQ-012 In OUT, the transfer completes when instr_valid=1 and instr_ready=1 in the same cycle:
- next state HALT if instr[31:25]=7'b1111111;
- next state FETCH otherwise.
REQ-013 In OUT with PCSrc=1:
- PC<=exNPC;
- next state FETCH, even if instr_ready=1 in the same cycle or instr is HALT;
- instr_valid SHALL be 0 the following cycle.
REQ-014 In HALT:
- halted=1 and imem_req=0;
- PCSrc=1 sets PC<=exNPC, halted<=0 and next state FETCH;
- otherwise the state is held.
REQ-015 Best-case throughput SHALL be one instruction per 3 cycles (FETCH, WAIT with 1-cycle memory, OUT with ready=1).
REQ-016 PCSrc SHALL take priority over every other event in every state except IDLE, where it is ignored.
REQ-017 instr_valid and halted SHALL be registered, i.e. decoded from registered state only.

Reset
REQ-018 rst_n=0 SHALL immediately force:
- state=IDLE;
- PC=0, squash=0;
- instr=0, instr_PC=0;
- instr_valid=0, imem_req=0, halted=0.
REQ-019 Reset asserted mid-request SHALL abandon the request; an imem_valid arriving after reset release while in IDLE SHALL be ignored.

Structure
REQ-020 The shared package kgp_pkg SHALL hold:
- PC_W=10, INSTR_W=32, OPC_W=3, FCODE_W=4, LABEL_W=25;
- HALT_OPC=3'b111, HALT_FCODE=4'b1111;
- the fetch state enum.
REQ-021 The PC register, with reset, increment and redirect load, SHALL be a sub-module named pc_reg; the FSM and output register SHALL stay in fetch_unit.

Verification
REQ-022 Straight-line fetch: 1-cycle memory, instr_ready=1, from reset → imem_addr sequence 0,1,2; instr_PC=0,1,2; instr_valid every 3rd cycle.
REQ-023 Backpressure: instr_ready=0 for 5 cycles in OUT with instr=32'h12345678 → instr and instr_PC=0 held stable; no imem_req issued until ready=1.
REQ-024 Redirect during WAIT: PC=120, PCSrc=1 with exNPC=150 one cycle before imem_valid → returned word discarded, instr_valid stays 0, next imem_addr=150.
REQ-025 Redirect in OUT with instr_ready=1 in the same cycle → transfer counts; next imem_addr=exNPC; instr_valid=0 the next cycle.
REQ-026 HALT and wrap: start at PC=1023 with word 32'hFE000000 → instr_PC=1023, then halted=1 and no further imem_req; PCSrc=1 with exNPC=0 → halted=0, next imem_addr=0.
REQ-027 Reset mid-WAIT: rst_n low for 1 cycle → all outputs 0 during reset; first imem_addr after release=0.

Source files
------------

// File: rtl/kgp_pkg.sv
// kgp_pkg: shared widths, HALT encoding and fetch state type
package kgp_pkg;
  localparam int PC_W = 10;
  localparam int INSTR_W = 32;
  localparam int OPC_W = 3;
  localparam int FCODE_W = 4;
  localparam int LABEL_W = 25;
  localparam logic [OPC_W-1:0] HALT_OPC = 3'b111;
  localparam logic [FCODE_W-1:0] HALT_FCODE = 4'b1111;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, OUT, HALT} fetchState_t;
  function automatic logic isHalt(input logic [INSTR_W-1:0] w);
    return w[INSTR_W-1 -: OPC_W+FCODE_W] == {HALT_OPC, HALT_FCODE};
  endfunction
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with redirect load and wrapping increment
module pc_reg import kgp_pkg::*; (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] loadVal,
  output logic [PC_W-1:0] pc
);
  // redirect wins over increment; increment wraps naturally at 2^PC_W
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= '0;
    else if (load) pc <= loadVal;
    else if (inc) pc <= pc + PC_W'(1);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM with redirect and HALT
module fetch_unit import kgp_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PCSrc,
  input  logic [PC_W-1:0]    exNPC,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_PC,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               halted
);
  fetchState_t state, nextState;
  logic squash;
  logic pcLoad;
  logic capture;
  logic [PC_W-1:0] pc;

  assign pcLoad = PCSrc && state != IDLE;
  assign capture = state == WAIT && imem_valid && !squash && !PCSrc;
  assign imem_addr = pc;
  assign instr_valid = state == OUT;
  assign halted = state == HALT;

  pc_reg uPc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pcLoad),
    .inc     (capture),
    .loadVal (exNPC),
    .pc      (pc)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nextState;

  // a redirect while waiting marks the in-flight word as stale until it returns
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) squash <= 1'b0;
    else if (state == WAIT) squash <= imem_valid ? 1'b0 : (PCSrc ? 1'b1 : squash);

  // capture the returned word and its PC for presentation to decode
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr <= '0;
      instr_PC <= '0;
    end else if (capture) begin
      instr <= imem_rdata;
      instr_PC <= pc;
    end

  // next state and request; redirect dominates everywhere except IDLE
  always_comb begin
    nextState = state;
    imem_req = 1'b0;
    case (state)
      IDLE:  nextState = FETCH;
      FETCH: begin
        imem_req = !PCSrc;
        nextState = PCSrc ? FETCH : WAIT;
      end
      WAIT:  nextState = imem_valid ? ((PCSrc || squash) ? FETCH : OUT) : WAIT;
      OUT:   nextState = PCSrc ? FETCH : (instr_ready ? (isHalt(instr) ? HALT : FETCH) : OUT);
      HALT:  nextState = PCSrc ? FETCH : HALT;
      default: nextState = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit
module tb_fetch_unit;
  logic clk = 0;
  logic rst_n = 0;
  logic PCSrc = 0;
  logic [9:0] exNPC = 0;
  logic imem_req;
  logic [9:0] imem_addr;
  logic imem_valid = 0;
  logic [31:0] imem_rdata = 0;
  logic [31:0] instr;
  logic [9:0] instr_PC;
  logic instr_valid;
  logic instr_ready = 0;
  logic halted;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCSrc       (PCSrc),
    .exNPC       (exNPC),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_PC    (instr_PC),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    int pc;
  } exp_t;

  exp_t expQ[$];
  logic [31:0] mem [1024];
  int total = 0;
  int passed = 0;
  int pcModel = 0;
  int pendAddr = 0;
  int lat = 0;
  int sinceReset = 0;
  int pRedir = 0;
  int pReady = 100;
  int maxLat = 0;
  int forceTgt = 0;
  bit pending = 0;
  bit discard = 0;
  bit stale = 0;
  bit forceRedir = 0;
  bit haltModel = 0;
  bit haltNext = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic resetCycle();
    @(negedge clk);
    rst_n = 0;
    PCSrc = 0;
    imem_valid = 0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_PC", 32'(instr_PC), 0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    expQ.delete();
    pcModel = 0;
    pending = 0;
    discard = 0;
    haltModel = 0;
    haltNext = 0;
    sinceReset = 0;
    stale = 1;
  endtask

  task automatic cycle();
    bit wasPending;
    @(negedge clk);
    rst_n = 1;
    if (pending && lat == 0) begin
      imem_valid = 1;
      imem_rdata = mem[pendAddr];
    end else begin
      imem_valid = stale;
      imem_rdata = $urandom;
      if (pending) lat--;
    end
    stale = 0;
    if (forceRedir) begin
      PCSrc = 1;
      exNPC = 10'(forceTgt);
      forceRedir = 0;
    end else begin
      PCSrc = sinceReset > 0 && int'($urandom % 100) < pRedir;
      exNPC = 10'($urandom);
    end
    instr_ready = int'($urandom % 100) < pReady;
    #3;
    wasPending = pending;
    if (imem_valid && pending) begin
      if (!discard && !PCSrc) begin
        expQ.push_back('{mem[pendAddr], pendAddr});
        pcModel = (pendAddr + 1) % 1024;
      end
      pending = 0;
      discard = 0;
    end
    if (PCSrc) begin
      pcModel = int'(exNPC);
      if (pending) discard = 1;
    end
    if (imem_req) begin
      chk("req_allowed", 32'(!wasPending && !haltModel && expQ.size() == 0), 1);
      chk("imem_addr", 32'(imem_addr), 32'(pcModel));
      pending = 1;
      pendAddr = pcModel;
      lat = $urandom_range(maxLat, 0);
    end
    sinceReset++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // monitor: compares presented instructions and status against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        haltModel = haltNext;
        chk("instr_valid", 32'(instr_valid), 32'(expQ.size() != 0));
        chk("halted", 32'(halted), 32'(haltModel));
        if (instr_valid && expQ.size() != 0) begin
          e = expQ[0];
          chk("instr", instr, e.w);
          chk("instr_PC", 32'(instr_PC), 32'(e.pc));
          if (instr_ready || PCSrc) begin
            void'(expQ.pop_front());
            if (!PCSrc && e.w[31:25] == 7'h7f) haltNext = 1;
          end
        end
        if (PCSrc) haltNext = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom % 20 == 0) ? {7'h7f, 25'($urandom)} : {1'b0, 31'($urandom)};
    mem[0] = 32'h12345678;
    for (int i = 1; i < 16; i++) mem[i] = {1'b0, 31'($urandom)};
    resetCycle();
    run(12);
    resetCycle();
    pReady = 0;
    run(8);
    pReady = 100;
    run(6);
    pRedir = 10;
    pReady = 70;
    maxLat = 2;
    run(600);
    pRedir = 0;
    pReady = 100;
    maxLat = 0;
    mem[1023] = 32'hFE000000;
    forceRedir = 1;
    forceTgt = 1023;
    run(10);
    chk("halt_reached", 32'(halted), 1);
    run(5);
    forceRedir = 1;
    forceTgt = 0;
    run(6);
    mem[1023] = 32'h00000001;
    forceRedir = 1;
    forceTgt = 1023;
    run(8);
    maxLat = 2;
    for (int i = 0; i < 20 && !pending; i++) cycle();
    chk("reach_wait", 32'(pending), 1);
    resetCycle();
    run(10);
    pRedir = 10;
    pReady = 70;
    run(300);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
